// File: rtl/bcd_clock_pkg.sv
// Shared types and constants for the BCD clock controller: FSM states,
// set_mode encodings and the BCD digit limits for hours and minutes.
package bcd_clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PULSE   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SET_HR  = 3'd3,
        ST_SET_MIN = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_HR  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN = 2'b10;

    localparam logic [3:0] BCD_LS_MAX     = 4'd9;
    localparam logic [3:0] BCD_MIN_MS_MAX = 4'd5;
    localparam logic [3:0] BCD_HR_MS_MAX  = 4'd2;
    localparam logic [3:0] BCD_HR_LS_MAX  = 4'd3;

    localparam int unsigned HR_MAX_VAL  = 32'd23;
    localparam int unsigned MIN_MAX_VAL = 32'd59;

    typedef struct packed {
        logic [3:0] ms;
        logic [3:0] ls;
    } bcd2_t;

    localparam bcd2_t BCD2_ZERO = '{ms: 4'd0, ls: 4'd0};

    // Externally visible set_mode code for a given controller state.
    function automatic logic [1:0] mode_of(input state_t st);
        logic [1:0] mode;
        case (st)
            ST_SET_HR:  mode = MODE_SET_HR;
            ST_SET_MIN: mode = MODE_SET_MIN;
            default:    mode = MODE_RUN;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// Wrapping two-digit BCD increment used while the user is setting a field.
// MAX_VAL is the last legal value (23 for hours, 59 for minutes).
module bcd_field_inc
    import bcd_clock_pkg::*;
#(
    parameter int unsigned MAX_VAL = MIN_MAX_VAL
)
(
    input  bcd2_t cur,
    output bcd2_t nxt
);

    localparam logic [3:0] MS_TOP = 4'(MAX_VAL / 32'd10);
    localparam logic [3:0] LS_TOP = 4'(MAX_VAL % 32'd10);

    // Top value wraps to 00; otherwise a units digit of 9 carries into tens.
    always_comb begin
        nxt = cur;
        if ((cur.ms == MS_TOP) && (cur.ls == LS_TOP)) begin
            nxt = BCD2_ZERO;
        end else if (cur.ls == BCD_LS_MAX) begin
            nxt.ms = cur.ms + 4'd1;
            nxt.ls = 4'd0;
        end else begin
            nxt.ms = cur.ms;
            nxt.ls = cur.ls + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_clock_ctrl.sv
// BCD wall-clock controller: counts seconds, sequences an external minute
// incrementer once per minute, and lets the user set hours and minutes.
module bcd_clock_ctrl
    import bcd_clock_pkg::*;
#(
    parameter int unsigned SEC_PER_MIN = 60
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [3:0] nxt_ms_hour,
    input  logic [3:0] nxt_ls_hour,
    input  logic [3:0] nxt_ms_min,
    input  logic [3:0] nxt_ls_min,
    output logic       add_one,
    output logic [3:0] ms_hour,
    output logic [3:0] ls_hour,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [1:0] set_mode
);

    localparam int unsigned     CNT_W    = 6;
    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SEC_PER_MIN - 32'd1);
    localparam logic [CNT_W-1:0] SEC_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] SEC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] sec_cnt_r;
    logic [CNT_W-1:0] sec_cnt_s;
    logic [CNT_W-1:0] sec_inc_s;
    logic             rollover_s;
    bcd2_t            hour_r;
    bcd2_t            hour_s;
    bcd2_t            min_r;
    bcd2_t            min_s;
    bcd2_t            hour_inc_s;
    bcd2_t            min_inc_s;
    logic             add_one_s;
    logic [1:0]       set_mode_s;

    bcd_field_inc #(.MAX_VAL(HR_MAX_VAL)) u_hour_inc (
        .cur (hour_r),
        .nxt (hour_inc_s)
    );

    bcd_field_inc #(.MAX_VAL(MIN_MAX_VAL)) u_min_inc (
        .cur (min_r),
        .nxt (min_inc_s)
    );

    assign rollover_s = sec_tick && (sec_cnt_r == SEC_LAST);
    assign sec_inc_s  = (sec_cnt_r == SEC_LAST) ? SEC_ZERO : (sec_cnt_r + SEC_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a rollover tick takes priority over mode_btn in RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (rollover_s) begin
                    state_s = ST_PULSE;
                end else if (mode_btn) begin
                    state_s = ST_SET_HR;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PULSE: state_s = ST_LOAD;
            ST_LOAD:  state_s = ST_RUN;
            ST_SET_HR: begin
                if (mode_btn) begin
                    state_s = ST_SET_MIN;
                end else begin
                    state_s = ST_SET_HR;
                end
            end
            ST_SET_MIN: begin
                if (mode_btn) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SET_MIN;
                end
            end
            default: state_s = ST_RUN;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with state_r.
    always_comb begin
        add_one_s  = 1'b0;
        set_mode_s = mode_of(state_s);
        if (state_s == ST_PULSE) begin
            add_one_s = 1'b1;
        end else begin
            add_one_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_one  <= 1'b0;
            set_mode <= MODE_RUN;
        end else begin
            add_one  <= add_one_s;
            set_mode <= set_mode_s;
        end
    end

    // Second counter: frozen while setting, cleared when leaving minute setting.
    always_comb begin
        sec_cnt_s = sec_cnt_r;
        case (state_r)
            ST_RUN, ST_PULSE, ST_LOAD: begin
                if (sec_tick) begin
                    sec_cnt_s = sec_inc_s;
                end else begin
                    sec_cnt_s = sec_cnt_r;
                end
            end
            ST_SET_HR: sec_cnt_s = sec_cnt_r;
            ST_SET_MIN: begin
                if (mode_btn) begin
                    sec_cnt_s = SEC_ZERO;
                end else begin
                    sec_cnt_s = sec_cnt_r;
                end
            end
            default: sec_cnt_s = SEC_ZERO;
        endcase
    end

    // Time fields: load from the external incrementer, or step while setting.
    always_comb begin
        hour_s = hour_r;
        min_s  = min_r;
        case (state_r)
            ST_LOAD: begin
                hour_s = {nxt_ms_hour, nxt_ls_hour};
                min_s  = {nxt_ms_min, nxt_ls_min};
            end
            ST_SET_HR: begin
                if (inc_btn && !mode_btn) begin
                    hour_s = hour_inc_s;
                end else begin
                    hour_s = hour_r;
                end
            end
            ST_SET_MIN: begin
                if (inc_btn && !mode_btn) begin
                    min_s = min_inc_s;
                end else begin
                    min_s = min_r;
                end
            end
            default: begin
                hour_s = hour_r;
                min_s  = min_r;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_cnt_r <= SEC_ZERO;
            hour_r    <= BCD2_ZERO;
            min_r     <= BCD2_ZERO;
        end else begin
            sec_cnt_r <= sec_cnt_s;
            hour_r    <= hour_s;
            min_r     <= min_s;
        end
    end

    assign ms_hour = hour_r.ms;
    assign ls_hour = hour_r.ls;
    assign ms_min  = min_r.ms;
    assign ls_min  = min_r.ls;

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Self-checking bench for bcd_clock_ctrl: an integer-level clock model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bcd_clock_ctrl;

    localparam int SPM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] nxt_ms_hour;
    logic [3:0] nxt_ls_hour;
    logic [3:0] nxt_ms_min;
    logic [3:0] nxt_ls_min;
    logic       add_one;
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
    logic [1:0] set_mode;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: hours/minutes as integers, mode 0=run 1=set hours 2=set minutes.
    int m_hour = 0;
    int m_min  = 0;
    int m_sec  = 0;
    int m_mode = 0;
    bit m_add_one  = 1'b0;
    bit m_load_due = 1'b0;

    always #5 clk = ~clk;

    bcd_clock_ctrl #(.SEC_PER_MIN(SPM)) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_tick    (sec_tick),
        .mode_btn    (mode_btn),
        .inc_btn     (inc_btn),
        .nxt_ms_hour (nxt_ms_hour),
        .nxt_ls_hour (nxt_ls_hour),
        .nxt_ms_min  (nxt_ms_min),
        .nxt_ls_min  (nxt_ls_min),
        .add_one     (add_one),
        .ms_hour     (ms_hour),
        .ls_hour     (ls_hour),
        .ms_min      (ms_min),
        .ls_min      (ls_min),
        .set_mode    (set_mode)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int now_hhmm();
        return int'(ms_hour) * 1000 + int'(ls_hour) * 100 + int'(ms_min) * 10 + int'(ls_min);
    endfunction

    // Behavioural clock model.
    always @(posedge clk) begin
        if (reset) begin
            m_hour <= 0; m_min <= 0; m_sec <= 0; m_mode <= 0;
            m_add_one <= 1'b0; m_load_due <= 1'b0;
        end else begin
            m_add_one  <= 1'b0;
            m_load_due <= m_add_one;
            if (m_add_one || m_load_due) begin
                if (sec_tick) m_sec <= (m_sec + 1) % SPM;
                if (m_load_due) begin
                    m_hour <= int'(nxt_ms_hour) * 10 + int'(nxt_ls_hour);
                    m_min  <= int'(nxt_ms_min) * 10 + int'(nxt_ls_min);
                end
            end else if (m_mode == 0) begin
                if (sec_tick && m_sec == SPM - 1) begin
                    m_sec <= 0;
                    m_add_one <= 1'b1;
                end else begin
                    if (sec_tick) m_sec <= m_sec + 1;
                    if (mode_btn) m_mode <= 1;
                end
            end else if (m_mode == 1) begin
                if (mode_btn) m_mode <= 2;
                else if (inc_btn) m_hour <= (m_hour + 1) % 24;
            end else begin
                if (mode_btn) begin
                    m_mode <= 0;
                    m_sec  <= 0;
                end else if (inc_btn) begin
                    m_min <= (m_min + 1) % 60;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("add_one", add_one, m_add_one);
            chk("set_mode", set_mode, m_mode);
            chk("ms_hour", ms_hour, m_hour / 10);
            chk("ls_hour", ls_hour, m_hour % 10);
            chk("ms_min", ms_min, m_min / 10);
            chk("ls_min", ls_min, m_min % 10);
        end
    end

    task automatic drive(input logic r, input logic t, input logic m, input logic i);
        @(negedge clk);
        reset = r; sec_tick = t; mode_btn = m; inc_btn = i;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_nxt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        nxt_ms_hour = a; nxt_ls_hour = b; nxt_ms_min = c; nxt_ls_min = d;
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        set_nxt(4'd0, 4'd0, 4'd0, 4'd0);
        cmp_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_time", now_hhmm(), 0);
        chk("rst_add_one", add_one, 0);
        chk("rst_set_mode", set_mode, 0);

        // First minute rollover with the incrementer presenting 00:01.
        set_nxt(4'd0, 4'd0, 4'd0, 4'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("pre_roll_add_one", add_one, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pulse_add_one", add_one, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("load_add_one", add_one, 0);
        chk("load_ls_min_old", ls_min, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat3_ls_min", ls_min, 1);

        // Jump to 22:00, then leave two ticks pending in sec_cnt.
        set_nxt(4'd2, 4'd2, 4'd0, 4'd0);
        for (int k = 0; k < SPM; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("time_2200", now_hhmm(), 2200);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Hour setting: ticks ignored, then 5 increments 22 -> 03.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2 * SPM; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sethr_ticks_time", now_hhmm(), 2200);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hour_03", now_hhmm(), 300);
        chk("sethr_mode", set_mode, 1);
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hour_10", now_hhmm(), 1000);

        // mode_btn beats inc_btn; then minutes 00 -> 59 -> 00.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mode_wins_time", now_hhmm(), 1000);
        chk("setmin_mode", set_mode, 2);
        for (int k = 0; k < 59; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("min_59", now_hhmm(), 1059);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("min_wrap_no_carry", now_hhmm(), 1000);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("back_to_run", set_mode, 0);

        // sec_cnt restarted at 0: three ticks must not roll over.
        set_nxt(4'd1, 4'd0, 4'd0, 4'd1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sec_cleared", add_one, 0);

        // Rollover tick together with mode_btn; buttons during PULSE/LOAD dropped.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("roll_mode_pulse", add_one, 1);
        chk("roll_mode_setmode", set_mode, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("load_setmode", set_mode, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("time_1001", now_hhmm(), 1001);
        chk("after_load_setmode", set_mode, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("later_mode_sethr", set_mode, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Non-rollover tick with mode_btn: counted, enters SET_HR; then reset mid-set.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tick_mode_sethr", set_mode, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_set_mode", set_mode, 0);
        chk("rst_in_set_time", now_hhmm(), 0);

        // Reset during PULSE: nothing captured.
        set_nxt(4'd1, 4'd2, 4'd3, 4'd4);
        for (int k = 0; k < SPM; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_pulse", add_one, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pulse_add_one", add_one, 0);
        chk("rst_pulse_time", now_hhmm(), 0);
        idle(3);
        chk("rst_pulse_no_capture", now_hhmm(), 0);

        // Normal operation resumes.
        for (int k = 0; k < SPM; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("time_1234", now_hhmm(), 1234);

        idle(2);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_clock_ctrl.md
BCD_CLOCK_CTRL -- requirements
Module: bcd_clock_ctrl

Interface
REQ-001 Parameter: SEC_PER_MIN, default 60, number of sec_tick pulses per minute; legal range 2..60.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sec_tick  input  1  one-cycle strobe, once per second.
REQ-005 mode_btn  input  1  one-cycle strobe, debounced upstream; advances set mode.
REQ-006 inc_btn  input  1  one-cycle strobe, debounced upstream; increments the selected field.
REQ-007 nxt_ms_hour, nxt_ls_hour, nxt_ms_min, nxt_ls_min  input  4 each  incremented time from the external BCD incrementer.
REQ-008 add_one  output  1  registered increment strobe to the incrementer.
REQ-009 ms_hour, ls_hour, ms_min, ls_min  output  4 each  registered current time in BCD; also drives the incrementer inputs.
REQ-010 set_mode  output  2  00 = run, 01 = setting hours, 10 = setting minutes.

Function
REQ-011 FSM states SHALL be RUN, PULSE, LOAD, SET_HR and SET_MIN.
REQ-012 RUN: each sec_tick SHALL increment sec_cnt (0..SEC_PER_MIN-1, internal).
REQ-013 RUN: sec_tick with sec_cnt == SEC_PER_MIN-1 SHALL clear sec_cnt and move to PULSE.
REQ-014 PULSE: add_one SHALL be 1 for exactly this one cycle; next state LOAD.
REQ-015 LOAD: add_one SHALL be 0; the time outputs SHALL capture the nxt_* inputs verbatim at the end of the cycle; next state RUN.
REQ-016 Latency: time outputs SHALL update 3 cycles after the rollover sec_tick cycle.
REQ-017 PULSE/LOAD: sec_tick SHALL still increment sec_cnt; mode_btn and inc_btn SHALL be dropped.
REQ-018 RUN: mode_btn SHALL go to SET_HR; SET_HR: mode_btn SHALL go to SET_MIN; SET_MIN: mode_btn SHALL clear sec_cnt and go to RUN.
REQ-019 SET_HR/SET_MIN: sec_tick SHALL be ignored and add_one SHALL stay 0.
REQ-020 SET_HR: inc_btn SHALL increment hours in BCD (ls 9 -> 0 with ms+1); 23 -> 00.
REQ-021 SET_MIN: inc_btn SHALL increment minutes in BCD; 59 -> 00, with no carry into hours.
REQ-022 inc_btn in RUN SHALL be ignored.
REQ-023 mode_btn and inc_btn in the same cycle: mode_btn SHALL win and inc_btn SHALL be dropped.
REQ-024 RUN, rollover sec_tick and mode_btn in the same cycle: the rollover SHALL win (go to PULSE) and mode_btn SHALL be dropped.
REQ-025 RUN, non-rollover sec_tick and mode_btn in the same cycle: the tick SHALL be counted and the FSM SHALL go to SET_HR.
REQ-026 set_mode SHALL be 00 in RUN, PULSE and LOAD; 01 in SET_HR; 10 in SET_MIN.

Reset
REQ-027 reset SHALL force RUN, sec_cnt = 0, add_one = 0, all time outputs = 0 and set_mode = 00 on the next edge.
REQ-028 reset SHALL override all other inputs, including mid-PULSE/LOAD (nxt_* not captured) and mid-set mode.

Structure
REQ-029 Package bcd_clock_pkg SHALL hold the state enum, the set_mode encodings and the BCD limit constants (9, 5, 2, 3).
REQ-030 Sub-module bcd_field_inc SHALL implement the wrapping two-digit BCD increment (parameterised max value 23 or 59) for set mode.
REQ-031 The minute incrementer SHALL remain external; this block only sequences it.

Verification
REQ-032 Reset; then SEC_PER_MIN=4, 4 sec_ticks, nxt_* = 0,0,0,1 -> add_one high exactly one cycle; ls_min = 1 three cycles after the 4th tick.
REQ-033 mode_btn, then 5 inc_btn, time 22:00 -> ms_hour:ls_hour = 0:3 (23->00->...->03), set_mode = 01.
REQ-034 In SET_MIN at 59, inc_btn -> min = 00 and hours unchanged; mode_btn -> set_mode = 00, sec_cnt = 0.
REQ-035 Rollover sec_tick and mode_btn in the same cycle -> PULSE taken, set_mode stays 00; a later mode_btn enters SET_HR.
REQ-036 reset asserted in the PULSE cycle -> add_one = 0 next cycle, time = 00:00, nxt_* ignored.
REQ-037 sec_ticks in SET_HR for 2*SEC_PER_MIN -> add_one never asserted; time unchanged.
